mem_operand_fetcher: RTL and testbench

Parametrised operand-fetch sequencer for memory-operand instructions in the multicycle processor. On a `start` pulse it captures up to NUM_OPS register values. Each value is used either directly as an operand, or as an address whose memory word becomes the operand. It runs its own FSM over a req/ack memory port and presents all operands to the datapath, for example the divider, with a one-cycle `done` pulse. This replaces control-unit-sequenced operand muxing with a self-timed block.

---
 rtl/mem_operand_fetcher.sv | 156 +++++++++++++++
 tb/tb_mem_operand_fetcher.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_operand_fetcher.sv
// Operand-fetch sequencer: captures NUM_OPS source values and passes each through or loads it from memory over a req/ack port.
// Optional watchdog on memory requests is built when FETCH_TIMEOUT_EN is defined.
module mem_operand_fetcher #(
  parameter int DATA_W         = 32,
  parameter int NUM_OPS        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_OPS-1:0]        indirect,
  input  logic [NUM_OPS*DATA_W-1:0] src,
  output logic                      mem_req,
  output logic [DATA_W-1:0]         mem_addr,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_OPS*DATA_W-1:0] ops,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_REQ,
    S_DONE
  } state_t;

  state_t                    state, state_next;
  logic [IDX_W-1:0]          idx;
  logic [NUM_OPS*DATA_W-1:0] src_q;
  logic [NUM_OPS-1:0]        ind_q;

  logic              latch_in;
  logic              op_we;
  logic [DATA_W-1:0] op_val;
  logic              idx_inc;
  logic              enter_req;
  logic              tmo_fire;
  logic              tmo_hit;
  logic [DATA_W-1:0] cur_src;
  logic              is_last;

  assign cur_src = src_q[idx*DATA_W +: DATA_W];
  assign is_last = (idx == LAST_IDX);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    latch_in   = 1'b0;
    op_we      = 1'b0;
    op_val     = '0;
    idx_inc    = 1'b0;
    enter_req  = 1'b0;
    tmo_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          latch_in   = 1'b1;
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (ind_q[idx]) begin
          enter_req  = 1'b1;
          state_next = S_REQ;
        end else begin
          op_we  = 1'b1;
          op_val = cur_src;
          if (is_last) state_next = S_DONE;
          else         idx_inc    = 1'b1;
        end
      end
      S_REQ: begin
        // An ack in the expiry cycle takes priority over the watchdog.
        if (mem_ack) begin
          op_we  = 1'b1;
          op_val = mem_rdata;
          if (is_last) begin
            state_next = S_DONE;
          end else begin
            idx_inc    = 1'b1;
            state_next = S_SCAN;
          end
        end else if (tmo_hit) begin
          op_we      = 1'b1;
          op_val     = '0;
          tmo_fire   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      src_q    <= '0;
      ind_q    <= '0;
      ops      <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state   <= state_next;
      mem_req <= (state_next == S_REQ);
      if (latch_in) begin
        src_q <= src;
        ind_q <= indirect;
        idx   <= '0;
      end else if (idx_inc) begin
        idx <= idx + IDX_W'(1);
      end
      if (enter_req) mem_addr <= cur_src;
      if (op_we) ops[idx*DATA_W +: DATA_W] <= op_val;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // tmo_cnt counts completed REQ cycles; expiry fires at the end of the TIMEOUT_CYCLES-th one.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (enter_req)            tmo_cnt <= '0;
      else if (state == S_REQ)  tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (latch_in)             err_q <= 1'b0;
      else if (tmo_fire)        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy = (state == S_SCAN) || (state == S_REQ);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mem_operand_fetcher.sv
// Directed self-checking bench for mem_operand_fetcher (DATA_W=32, NUM_OPS=2, TIMEOUT_CYCLES=4).
module tb_mem_operand_fetcher;

  localparam int DATA_W  = 32;
  localparam int NUM_OPS = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      start;
  logic [NUM_OPS-1:0]        indirect;
  logic [NUM_OPS*DATA_W-1:0] src;
  logic                      mem_req;
  logic [DATA_W-1:0]         mem_addr;
  logic                      mem_ack;
  logic [DATA_W-1:0]         mem_rdata;
  logic [NUM_OPS*DATA_W-1:0] ops;
  logic                      busy;
  logic                      done;
  logic                      err;

  int tests = 0;
  int fails = 0;

  mem_operand_fetcher #(
    .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .indirect(indirect), .src(src),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ops(ops), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flag bundle {mem_req, busy, done, err} to keep control checks compact.
  function automatic logic [63:0] flags();
    return {60'd0, mem_req, busy, done, err};
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; indirect = '0; src = '0; mem_ack = 1'b1; mem_rdata = '0;

    // Reset, with a stray ack while idle.
    tick(); tick(); tick();
    check("rst_flags", flags(), 64'h0);
    check("rst_ops", ops, 64'h0);
    reset = 1'b1;
    tick();
    check("idle_ack_flags", flags(), 64'h0);
    check("idle_ack_addr", {32'd0, mem_addr}, 64'h0);
    check("idle_ack_ops", ops, 64'h0);
    mem_ack = 1'b0;

    // Both direct: done in cycle 3.
    indirect = 2'b00; src = {32'h7, 32'h15}; start = 1'b1;
    tick(); start = 1'b0;
    check("dir_c1", flags(), 64'b0100);
    tick();
    check("dir_c2", flags(), 64'b0100);
    tick();
    check("dir_c3_flags", flags(), 64'b0010);
    check("dir_c3_ops", ops, {32'h7, 32'h15});
    tick();
    check("dir_c4_flags", flags(), 64'b0000);

    // Both indirect, L=3: [0x100]=40, [0x200]=8, done in cycle 9.
    indirect = 2'b11; src = {32'h200, 32'h100}; start = 1'b1;
    tick(); start = 1'b0;
    check("ind_c1", flags(), 64'b0100);
    tick();
    check("ind_c2_flags", flags(), 64'b1100);
    check("ind_c2_addr", {32'd0, mem_addr}, 64'h100);
    tick();
    check("ind_c3_addr", {32'd0, mem_addr}, 64'h100);
    tick();
    check("ind_c4_flags", flags(), 64'b1100);
    check("ind_c4_addr", {32'd0, mem_addr}, 64'h100);
    mem_ack = 1'b1; mem_rdata = 32'd40;
    tick(); mem_ack = 1'b0; mem_rdata = '0;
    check("ind_c5_flags", flags(), 64'b0100);
    check("ind_c5_addr_hold", {32'd0, mem_addr}, 64'h100);
    check("ind_c5_slot0", ops, {32'h7, 32'd40});
    tick();
    check("ind_c6_addr", {32'd0, mem_addr}, 64'h200);
    tick();
    check("ind_c7_flags", flags(), 64'b1100);
    tick();
    check("ind_c8_addr", {32'd0, mem_addr}, 64'h200);
    mem_ack = 1'b1; mem_rdata = 32'd8;
    tick(); mem_ack = 1'b0; mem_rdata = '0;
    check("ind_c9_flags", flags(), 64'b0010);
    check("ind_c9_ops", ops, {32'd8, 32'd40});

    // Mixed: slot 0 from memory (L=1), slot 1 direct; start pulses while busy/done are ignored.
    tick();
    indirect = 2'b01; src = {32'hAA, 32'h300}; start = 1'b1;
    tick();
    check("mix_c1", flags(), 64'b0100);
    tick();
    check("mix_c2_flags", flags(), 64'b1100);
    check("mix_c2_addr", {32'd0, mem_addr}, 64'h300);
    check("mix_c2_ops_old", ops, {32'd8, 32'd40});
    mem_ack = 1'b1; mem_rdata = 32'h55;
    tick(); mem_ack = 1'b0; mem_rdata = '0;
    check("mix_c3", flags(), 64'b0100);
    tick();
    check("mix_c4_flags", flags(), 64'b0010);
    check("mix_c4_ops", ops, {32'hAA, 32'h55});
    start = 1'b0;
    tick();
    check("mix_c5_idle", flags(), 64'b0000);
    tick();
    check("mix_c6_idle", flags(), 64'b0000);

    // Reset during REQ with ack pending; a later ack is ignored.
    indirect = 2'b01; src = {32'h1, 32'h400}; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("rreq_c2_flags", flags(), 64'b1100);
    check("rreq_c2_addr", {32'd0, mem_addr}, 64'h400);
    reset = 1'b0;
    tick();
    check("rreq_flags", flags(), 64'b0000);
    check("rreq_ops", ops, 64'h0);
    check("rreq_addr", {32'd0, mem_addr}, 64'h0);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD;
    tick(); mem_ack = 1'b0; mem_rdata = '0;
    check("late_ack_flags", flags(), 64'b0000);
    check("late_ack_ops", ops, 64'h0);

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: slot 1 direct-loaded first so its retained value is visible after the timeout.
    indirect = 2'b00; src = {32'h66, 32'h77}; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    indirect = 2'b11; src = {32'h9, 32'h500}; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    check("tmo_c4_flags", flags(), 64'b1100);
    tick();
    check("tmo_c5_flags", flags(), 64'b1100);
    tick();
    check("tmo_c6_flags", flags(), 64'b0011);
    check("tmo_c6_ops", ops, {32'h66, 32'h0});
    tick();
    check("tmo_sticky", flags(), 64'b0001);
    indirect = 2'b00; src = {32'h2, 32'h3}; start = 1'b1;
    tick(); start = 1'b0;
    check("tmo_clear", flags(), 64'b0100);
    tick(); tick(); tick();
`else
    // No watchdog: REQ waits indefinitely and err stays low.
    indirect = 2'b01; src = {32'h2, 32'h600}; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("wait_flags", flags(), 64'b1100);
    mem_ack = 1'b1; mem_rdata = 32'h11;
    tick(); mem_ack = 1'b0; mem_rdata = '0;
    tick();
    check("wait_done", flags(), 64'b0010);
    check("wait_ops", ops, {32'h2, 32'h11});
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
